// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder walks the operands LSB-first over WIDTH cycles.
// Define SERIAL_ADDER_SAT999_EN to clamp results to the 0..999 display range and flag ovf.
module serial_adder #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy, r_done;
  logic [WIDTH:0]   r_sum;
  logic             r_ovf;

  logic             w_s, w_c, w_last;
  logic [WIDTH-1:0] w_res_nxt;
  logic [WIDTH:0]   w_raw, w_final;
  logic             w_ovf;

  assign w_s       = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c       = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
  assign w_res_nxt = {w_s, r_res[WIDTH-1:1]};
  assign w_raw     = {w_c, w_res_nxt};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

`ifdef SERIAL_ADDER_SAT999_EN
  logic [31:0] w_raw32;
  assign w_raw32 = 32'(w_raw);
  assign w_ovf   = (w_raw32 > 32'd999);
  assign w_final = w_ovf ? (WIDTH+1)'(999) : w_raw;
`else
  assign w_ovf   = 1'b0;
  assign w_final = w_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_carry <= w_c;
          r_res   <= w_res_nxt;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum   <= w_final;
            r_ovf   <= w_ovf;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          // DONE always lasts one cycle; a start held through it chains the
          // next operation so continuous requests run every WIDTH+1 cycles.
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
`ifdef SERIAL_ADDER_SAT999_EN
  assign ovf  = r_ovf;
`else
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed vector bench for serial_adder: table of operand pairs plus
// hand-written reset, ignored-start and back-to-back sequences.
module tb_serial_adder;

  localparam int W = 9;

  logic         clk, rst_n, start;
  logic [W-1:0] a, b;
  logic         busy, done, ovf;
  logic [W:0]   sum;

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           raw;
    int           sat;
    logic         sat_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int exp_sum(input vec_t v);
`ifdef SERIAL_ADDER_SAT999_EN
    return v.sat;
`else
    return v.raw;
`endif
  endfunction

  function automatic logic exp_ovf(input vec_t v);
`ifdef SERIAL_ADDER_SAT999_EN
    return v.sat_ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Start at edge T, scramble operands afterwards, check every cycle through T+W+1.
  task automatic run_op(input vec_t v);
    logic [W:0] prev_sum;
    logic       prev_ovf;
    @(negedge clk);
    prev_sum = sum;
    prev_ovf = ovf;
    a = v.a; b = v.b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    for (int i = 0; i < W; i++) begin
      chk($sformatf("busy_c%0d", i), 32'(busy), 32'd1);
      chk($sformatf("done_c%0d", i), 32'(done), 32'd0);
      chk($sformatf("sumhold_c%0d", i), 32'(sum), 32'(prev_sum));
      chk($sformatf("ovfhold_c%0d", i), 32'(ovf), 32'(prev_ovf));
      @(posedge clk);
      #1;
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk($sformatf("sum_%0d+%0d", v.a, v.b), 32'(sum), 32'(exp_sum(v)));
    chk($sformatf("ovf_%0d+%0d", v.a, v.b), 32'(ovf), 32'(exp_ovf(v)));
    @(posedge clk);
    #1;
    chk("done_drop", 32'(done), 32'd0);
    chk("sum_after", 32'(sum), 32'(exp_sum(v)));
  endtask

  vec_t vecs[8];
  int   dones;
  vec_t v;

  initial begin
    vecs[0] = '{a: 9'd5,   b: 9'd7,   raw: 12,   sat: 12,  sat_ovf: 1'b0};
    vecs[1] = '{a: 9'd511, b: 9'd511, raw: 1022, sat: 999, sat_ovf: 1'b1};
    vecs[2] = '{a: 9'd0,   b: 9'd0,   raw: 0,    sat: 0,   sat_ovf: 1'b0};
    vecs[3] = '{a: 9'd511, b: 9'd1,   raw: 512,  sat: 512, sat_ovf: 1'b0};
    vecs[4] = '{a: 9'd300, b: 9'd256, raw: 556,  sat: 556, sat_ovf: 1'b0};
    vecs[5] = '{a: 9'd500, b: 9'd500, raw: 1000, sat: 999, sat_ovf: 1'b1};
    vecs[6] = '{a: 9'd499, b: 9'd500, raw: 999,  sat: 999, sat_ovf: 1'b0};
    vecs[7] = '{a: 9'd255, b: 9'd256, raw: 511,  sat: 511, sat_ovf: 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_ovf",  32'(ovf),  32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset mid-run after a saturating result: outputs clear without a clock edge.
    @(negedge clk);
    a = 9'd511; b = 9'd511; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (W + 3) @(posedge clk);
    a = 9'd400; b = 9'd100; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    chk("async_sum",  32'(sum),  32'd0);
    chk("async_ovf",  32'(ovf),  32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Start pulsed again during SHIFT must be ignored.
    @(negedge clk);
    a = 9'd100; b = 9'd23; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    dones = 0;
    for (int i = 1; i <= W + 6; i++) begin
      if (i == 3) begin a = 9'd1; b = 9'd1; start = 1'b1; end
      @(posedge clk); #1;
      if (i == 3) start = 1'b0;
      if (done) dones++;
    end
    chk("ign_sum", 32'(sum), 32'd123);
    chk("ign_dones", 32'(dones), 32'd1);

    // Reset abort: no done and no partial result afterwards.
    @(negedge clk);
    a = 9'd300; b = 9'd300; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    chk("abort_activity", 32'(dones), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    v = '{a: 9'd0, b: 9'd0, raw: 0, sat: 0, sat_ovf: 1'b0};
    run_op(v);

    // Start held high: completions every W+1 cycles.
    @(negedge clk);
    a = 9'd200; b = 9'd199; start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 2*W + 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b_done_%0d", i), 32'(done),
          32'((i == W || i == 2*W + 1) ? 1 : 0));
      if (done) chk($sformatf("b2b_sum_%0d", i), 32'(sum), 32'd399);
      if (i == 2*W + 1) start = 1'b0;
    end
    chk("b2b_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
